// File: rtl/conv_pkg.sv
// Shared state encoding and border-flag bit positions for the convolution
// frame sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VSYNC,
        S_FRAME,
        S_FLUSH
    } ctrl_state_t;

    localparam int unsigned BRD_LEFT   = 3;
    localparam int unsigned BRD_RIGHT  = 2;
    localparam int unsigned BRD_TOP    = 1;
    localparam int unsigned BRD_BOTTOM = 0;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter with clear, advance and forced new-line.
// Columns wrap at W-1; rows saturate at H-1.
module raster_counter #(
    parameter int unsigned W  = 640,
    parameter int unsigned H  = 480,
    parameter int unsigned CW = $clog2(W),
    parameter int unsigned RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          nl_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          col_last_o,
    output logic          row_last_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] row_inc;

    assign col_last_o = (col_q == CW'(W - 1));
    assign row_last_o = (row_q == RW'(H - 1));
    // Overrunning rows stay pinned to the bottom line instead of wrapping.
    assign row_inc    = row_last_o ? row_q : row_q + 1'b1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (nl_i) begin
            col_d = '0;
            row_d = row_inc;
        end else if (en_i) begin
            if (col_last_o) begin
                col_d = '0;
                row_d = row_inc;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution window: sync decode, shift gating,
// centre-pixel tracking with border flags, per-frame config and end-of-frame flush.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned KSEL_W       = 2
) (
    input  logic                            clk,
    input  logic                            rst_ni,
    input  logic                            vs_ni,
    input  logic                            hs_ni,
    input  logic                            blank_ni,
    input  logic [KSEL_W-1:0]               cfg_ksel_i,
    input  logic                            cfg_bypass_i,
    output logic                            win_en_o,
    output logic                            flush_o,
    output logic                            ctr_valid_o,
    output logic [$clog2(LINE_WIDTH)-1:0]   ctr_col_o,
    output logic [$clog2(FRAME_HEIGHT)-1:0] ctr_row_o,
    output logic [3:0]                      border_o,
    output logic [KSEL_W-1:0]               ksel_o,
    output logic                            bypass_o,
    output logic                            frame_start_o,
    output logic                            line_err_o
);

    localparam int unsigned CW = $clog2(LINE_WIDTH);
    localparam int unsigned RW = $clog2(FRAME_HEIGHT);
    localparam int unsigned SW = $clog2(LINE_WIDTH + 2);
    localparam int unsigned FW = $clog2(LINE_WIDTH + 1);
    localparam logic [SW-1:0] SH_CTR  = SW'(LINE_WIDTH + 1);
    localparam logic [FW-1:0] FL_LAST = FW'(LINE_WIDTH);

    ctrl_state_t       state_q, state_d;
    logic              vs_prev_q, vs_prev_d, blank_prev_q, blank_prev_d;
    logic [SW-1:0]     sh_cnt_q, sh_cnt_d;
    logic [FW-1:0]     fl_cnt_q, fl_cnt_d;
    logic              first_q, first_d, in_done_q, in_done_d, ctr_done_q, ctr_done_d;
    logic              win_en_q, win_en_d, flush_q, flush_d, ctr_valid_q, ctr_valid_d;
    logic [CW-1:0]     ctr_col_q, ctr_col_d;
    logic [RW-1:0]     ctr_row_q, ctr_row_d;
    logic [3:0]        border_q, border_d;
    logic [KSEL_W-1:0] ksel_q, ksel_d;
    logic              bypass_q, bypass_d, frame_start_q, frame_start_d, line_err_q, line_err_d;

    logic              vs_rise, shift, start_frame;
    logic              in_clr, in_en, in_nl, c_clr, c_en;
    logic [CW-1:0]     in_col, c_col;
    logic [RW-1:0]     in_row, c_row;
    logic              in_col_last, in_row_last, c_col_last, c_row_last;
    logic              unused_ok;

    // Line boundaries come from blank_ni; hs_ni is carried for interface compatibility.
    assign unused_ok = ^{hs_ni, in_row};

    raster_counter #(.W(LINE_WIDTH), .H(FRAME_HEIGHT), .CW(CW), .RW(RW)) u_in (
        .clk(clk), .rst_ni(rst_ni), .clr_i(in_clr), .en_i(in_en), .nl_i(in_nl),
        .col_o(in_col), .row_o(in_row), .col_last_o(in_col_last), .row_last_o(in_row_last)
    );

    raster_counter #(.W(LINE_WIDTH), .H(FRAME_HEIGHT), .CW(CW), .RW(RW)) u_ctr (
        .clk(clk), .rst_ni(rst_ni), .clr_i(c_clr), .en_i(c_en), .nl_i(1'b0),
        .col_o(c_col), .row_o(c_row), .col_last_o(c_col_last), .row_last_o(c_row_last)
    );

    always_comb begin
        state_d       = state_q;
        vs_prev_d     = vs_ni;
        blank_prev_d  = blank_ni;
        sh_cnt_d      = sh_cnt_q;
        fl_cnt_d      = fl_cnt_q;
        first_d       = first_q;
        in_done_d     = in_done_q;
        ctr_done_d    = ctr_done_q;
        win_en_d      = 1'b0;
        flush_d       = 1'b0;
        ctr_valid_d   = 1'b0;
        ctr_col_d     = '0;
        ctr_row_d     = '0;
        border_d      = '0;
        ksel_d        = ksel_q;
        bypass_d      = bypass_q;
        frame_start_d = 1'b0;
        line_err_d    = line_err_q;
        vs_rise       = vs_ni && !vs_prev_q;
        shift         = 1'b0;
        start_frame   = 1'b0;
        in_clr        = 1'b0;
        in_en         = 1'b0;
        in_nl         = 1'b0;
        c_clr         = 1'b0;
        c_en          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!vs_ni) state_d = S_VSYNC;
            end
            S_VSYNC: begin
                if (vs_rise) start_frame = 1'b1;
            end
            S_FRAME: begin
                if (!vs_ni) begin
                    state_d  = (sh_cnt_q >= SH_CTR) ? S_FLUSH : S_VSYNC;
                    fl_cnt_d = '0;
                end else if (blank_ni) begin
                    shift = 1'b1;
                    in_en = 1'b1;
                    if (in_done_q) line_err_d = 1'b1;
                    if (in_col_last && in_row_last) in_done_d = 1'b1;
                    if (first_q) begin
                        frame_start_d = 1'b1;
                        first_d       = 1'b0;
                    end
                end else if (blank_prev_q && (in_col != '0)) begin
                    line_err_d = 1'b1;
                    in_nl      = 1'b1;
                end
            end
            S_FLUSH: begin
                shift    = 1'b1;
                flush_d  = 1'b1;
                fl_cnt_d = fl_cnt_q + 1'b1;
                // A rise on the final flush cycle already honours the minimum
                // vsync width, so it opens the next frame instead of being lost.
                if (fl_cnt_q == FL_LAST) begin
                    if (vs_rise) start_frame = 1'b1;
                    else         state_d = S_VSYNC;
                end else if (vs_rise) begin
                    line_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (shift) begin
            win_en_d = 1'b1;
            if (sh_cnt_q != SH_CTR) sh_cnt_d = sh_cnt_q + 1'b1;
            if ((sh_cnt_q >= SH_CTR) && !ctr_done_q) begin
                ctr_valid_d          = 1'b1;
                c_en                 = 1'b1;
                ctr_col_d            = c_col;
                ctr_row_d            = c_row;
                border_d[BRD_LEFT]   = (c_col == '0);
                border_d[BRD_RIGHT]  = c_col_last;
                border_d[BRD_TOP]    = (c_row == '0);
                border_d[BRD_BOTTOM] = c_row_last;
                if (c_col_last && c_row_last) ctr_done_d = 1'b1;
            end
        end

        if (start_frame) begin
            state_d    = S_FRAME;
            ksel_d     = cfg_ksel_i;
            bypass_d   = cfg_bypass_i;
            in_clr     = 1'b1;
            c_clr      = 1'b1;
            sh_cnt_d   = '0;
            first_d    = 1'b1;
            in_done_d  = 1'b0;
            ctr_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            vs_prev_q     <= 1'b0;
            blank_prev_q  <= 1'b0;
            sh_cnt_q      <= '0;
            fl_cnt_q      <= '0;
            first_q       <= 1'b0;
            in_done_q     <= 1'b0;
            ctr_done_q    <= 1'b0;
            win_en_q      <= 1'b0;
            flush_q       <= 1'b0;
            ctr_valid_q   <= 1'b0;
            ctr_col_q     <= '0;
            ctr_row_q     <= '0;
            border_q      <= '0;
            ksel_q        <= '0;
            bypass_q      <= 1'b0;
            frame_start_q <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_prev_q     <= vs_prev_d;
            blank_prev_q  <= blank_prev_d;
            sh_cnt_q      <= sh_cnt_d;
            fl_cnt_q      <= fl_cnt_d;
            first_q       <= first_d;
            in_done_q     <= in_done_d;
            ctr_done_q    <= ctr_done_d;
            win_en_q      <= win_en_d;
            flush_q       <= flush_d;
            ctr_valid_q   <= ctr_valid_d;
            ctr_col_q     <= ctr_col_d;
            ctr_row_q     <= ctr_row_d;
            border_q      <= border_d;
            ksel_q        <= ksel_d;
            bypass_q      <= bypass_d;
            frame_start_q <= frame_start_d;
            line_err_q    <= line_err_d;
        end
    end

    assign win_en_o      = win_en_q;
    assign flush_o       = flush_q;
    assign ctr_valid_o   = ctr_valid_q;
    assign ctr_col_o     = ctr_col_q;
    assign ctr_row_o     = ctr_row_q;
    assign border_o      = border_q;
    assign ksel_o        = ksel_q;
    assign bypass_o      = bypass_q;
    assign frame_start_o = frame_start_q;
    assign line_err_o    = line_err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl at W=8, H=4 with hand-computed expectations.
module tb_conv_frame_ctrl;
    import conv_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic       clk = 1'b0;
    logic       rst_ni, vs_ni, hs_ni, blank_ni;
    logic [1:0] cfg_ksel_i;
    logic       cfg_bypass_i;
    logic       win_en_o, flush_o, ctr_valid_o;
    logic [2:0] ctr_col_o;
    logic [1:0] ctr_row_o;
    logic [3:0] border_o;
    logic [1:0] ksel_o;
    logic       bypass_o, frame_start_o, line_err_o;
    logic [16:0] all_outs;

    int n_checks = 0;
    int n_errors = 0;
    int n_win, n_frame_win, n_flush, n_valid, n_fs, n_bad;
    int fv_shift, fs_shift, fv_col, fv_row, lv_col, lv_row;
    logic [3:0] fv_border, lv_border;
    logic [1:0] ksel_start, ksel_mid, ksel_end;
    logic       byp_start, byp_end;
    logic       err_after [4];
    int         col_after [4];
    int         row_after [4];

    conv_frame_ctrl #(.LINE_WIDTH(W), .FRAME_HEIGHT(H), .KSEL_W(2)) dut (
        .clk(clk), .rst_ni(rst_ni), .vs_ni(vs_ni), .hs_ni(hs_ni), .blank_ni(blank_ni),
        .cfg_ksel_i(cfg_ksel_i), .cfg_bypass_i(cfg_bypass_i),
        .win_en_o(win_en_o), .flush_o(flush_o), .ctr_valid_o(ctr_valid_o),
        .ctr_col_o(ctr_col_o), .ctr_row_o(ctr_row_o), .border_o(border_o),
        .ksel_o(ksel_o), .bypass_o(bypass_o), .frame_start_o(frame_start_o),
        .line_err_o(line_err_o)
    );

    assign all_outs = {win_en_o, flush_o, ctr_valid_o, ctr_col_o, ctr_row_o, border_o,
                       ksel_o, bypass_o, frame_start_o, line_err_o};

    always #5 clk = ~clk;

    task automatic clear_mon();
        n_win = 0; n_frame_win = 0; n_flush = 0; n_valid = 0; n_fs = 0; n_bad = 0;
        fv_shift = -1; fs_shift = -1; fv_col = -1; fv_row = -1; lv_col = -1; lv_row = -1;
        fv_border = 4'hx; lv_border = 4'hx;
    endtask

    // One input cycle; outputs are read 1 time unit after the edge that samples it.
    task automatic drive(input logic v, input logic b);
        vs_ni = v; blank_ni = b; hs_ni = b;
        @(posedge clk); #1;
        if (win_en_o) begin
            n_win++;
            if (!flush_o) n_frame_win++;
        end
        if (flush_o) n_flush++;
        if (frame_start_o) begin
            n_fs++;
            fs_shift = n_win;
        end
        if (ctr_valid_o && !win_en_o) n_bad++;
        if (ctr_valid_o) begin
            n_valid++;
            if (n_valid == 1) begin
                fv_shift = n_win; fv_col = int'(ctr_col_o); fv_row = int'(ctr_row_o); fv_border = border_o;
            end
            lv_col = int'(ctr_col_o); lv_row = int'(ctr_row_o); lv_border = border_o;
        end
    endtask

    // Expects vs_ni low on entry; leaves vs_ni low after vs_low cycles.
    task automatic send_frame(input int n_lines, input int short_idx, input int vs_low,
                              input logic [1:0] mid_ksel, input logic mid_byp);
        drive(1'b1, 1'b0);
        ksel_start = ksel_o; byp_start = bypass_o;
        drive(1'b1, 1'b0);
        for (int l = 0; l < n_lines; l++) begin
            for (int p = 0; p < ((l == short_idx) ? int'(W) - 1 : int'(W)); p++) drive(1'b1, 1'b1);
            if (l == 1) begin
                cfg_ksel_i = mid_ksel; cfg_bypass_i = mid_byp;
            end
            drive(1'b1, 1'b0);
            if (l < 4) begin
                err_after[l] = line_err_o;
                col_after[l] = int'(dut.u_in.col_o);
                row_after[l] = int'(dut.u_in.row_o);
            end
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b0);
        end
        ksel_mid = ksel_o;
        for (int c = 0; c < vs_low; c++) drive(1'b0, 1'b0);
        ksel_end = ksel_o; byp_end = bypass_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        n_checks++; if (all_outs !== '0) begin n_errors++; $display("FAIL reset_outs got %h want 0", all_outs); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, S_IDLE); end
        rst_ni = 1'b1;
        clear_mon();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
        n_checks++; if (n_win !== 0) begin n_errors++; $display("FAIL midframe_join_shifts got %0d want 0", n_win); end
        n_checks++; if (all_outs !== '0) begin n_errors++; $display("FAIL idle_outs got %h want 0", all_outs); end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        n_checks++; if (dut.state_q !== S_VSYNC) begin n_errors++; $display("FAIL vsync_state got %0d want %0d", dut.state_q, S_VSYNC); end
    endtask

    task automatic check_clean(input string tag);
        n_checks++; if (n_frame_win !== 32) begin n_errors++; $display("FAIL %s frame_shifts got %0d want 32", tag, n_frame_win); end
        n_checks++; if (fs_shift !== 1 || n_fs !== 1) begin n_errors++; $display("FAIL %s frame_start got at=%0d n=%0d want at=1 n=1", tag, fs_shift, n_fs); end
        n_checks++; if (fv_shift !== 10) begin n_errors++; $display("FAIL %s first_valid_shift got %0d want 10", tag, fv_shift); end
        n_checks++; if (fv_col !== 0 || fv_row !== 0 || fv_border !== 4'b1010) begin n_errors++; $display("FAIL %s first_centre got (%0d,%0d) %b want (0,0) 1010", tag, fv_col, fv_row, fv_border); end
        n_checks++; if (n_flush !== 9) begin n_errors++; $display("FAIL %s flush_cycles got %0d want 9", tag, n_flush); end
        n_checks++; if (n_valid !== 32) begin n_errors++; $display("FAIL %s valid_count got %0d want 32", tag, n_valid); end
        n_checks++; if (lv_col !== 7 || lv_row !== 3 || lv_border !== 4'b0101) begin n_errors++; $display("FAIL %s last_centre got (%0d,%0d) %b want (7,3) 0101", tag, lv_col, lv_row, lv_border); end
        n_checks++; if (n_bad !== 0) begin n_errors++; $display("FAIL %s valid_without_shift got %0d want 0", tag, n_bad); end
    endtask

    task automatic test_clean_frame();
        clear_mon();
        send_frame(4, -1, 12, 2'd0, 1'b0);
        check_clean("clean");
        n_checks++; if (line_err_o !== 1'b0) begin n_errors++; $display("FAIL clean_line_err got %b want 0", line_err_o); end
    endtask

    task automatic test_cfg_latch();
        clear_mon();
        send_frame(4, -1, 12, 2'd2, 1'b1);
        n_checks++; if (ksel_start !== 2'd0 || ksel_mid !== 2'd0 || ksel_end !== 2'd0 || byp_end !== 1'b0) begin
            n_errors++; $display("FAIL cfg_frame_a got ksel %0d/%0d/%0d byp %b want 0/0/0 byp 0", ksel_start, ksel_mid, ksel_end, byp_end); end
        send_frame(4, -1, 12, 2'd1, 1'b0);
        n_checks++; if (ksel_start !== 2'd2 || byp_start !== 1'b1) begin n_errors++; $display("FAIL cfg_latch got ksel %0d byp %b want 2 byp 1", ksel_start, byp_start); end
        n_checks++; if (ksel_mid !== 2'd2 || ksel_end !== 2'd2 || byp_end !== 1'b1) begin
            n_errors++; $display("FAIL cfg_hold got ksel %0d/%0d byp %b want 2/2 byp 1", ksel_mid, ksel_end, byp_end); end
    endtask

    task automatic test_short_line();
        clear_mon();
        send_frame(4, 1, 12, cfg_ksel_i, cfg_bypass_i);
        n_checks++; if (err_after[0] !== 1'b0 || err_after[1] !== 1'b1) begin n_errors++; $display("FAIL short_err_set got %b,%b want 0,1", err_after[0], err_after[1]); end
        n_checks++; if (col_after[1] !== 0 || row_after[1] !== 2) begin n_errors++; $display("FAIL short_realign got (%0d,%0d) want (0,2)", col_after[1], row_after[1]); end
        n_checks++; if (col_after[2] !== 0 || row_after[2] !== 3) begin n_errors++; $display("FAIL short_next_line got (%0d,%0d) want (0,3)", col_after[2], row_after[2]); end
        n_checks++; if (n_frame_win !== 31 || n_valid !== 31) begin n_errors++; $display("FAIL short_counts got shifts %0d valid %0d want 31 31", n_frame_win, n_valid); end
        n_checks++; if (lv_col !== 6 || lv_row !== 3 || lv_border !== 4'b0001) begin n_errors++; $display("FAIL short_last got (%0d,%0d) %b want (6,3) 0001", lv_col, lv_row, lv_border); end
        clear_mon();
        send_frame(4, -1, 12, cfg_ksel_i, cfg_bypass_i);
        n_checks++; if (err_after[0] !== 1'b1 || line_err_o !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b,%b want 1,1", err_after[0], line_err_o); end
    endtask

    task automatic test_short_vsync();
        rst_ni = 1'b0;
        drive(1'b0, 1'b0);
        rst_ni = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        clear_mon();
        send_frame(4, -1, 4, cfg_ksel_i, cfg_bypass_i);
        n_checks++; if (err_after[3] !== 1'b0) begin n_errors++; $display("FAIL vs_pre_err got %b want 0", err_after[3]); end
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
        n_checks++; if (n_flush !== 9) begin n_errors++; $display("FAIL vs_short_flush got %0d want 9", n_flush); end
        n_checks++; if (line_err_o !== 1'b1) begin n_errors++; $display("FAIL vs_short_err got %b want 1", line_err_o); end
        n_checks++; if (dut.state_q !== S_VSYNC || n_fs !== 1) begin n_errors++; $display("FAIL vs_short_state got %0d fs %0d want %0d fs 1", dut.state_q, n_fs, S_VSYNC); end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        clear_mon();
        send_frame(4, -1, 12, cfg_ksel_i, cfg_bypass_i);
        n_checks++; if (n_fs !== 1 || n_frame_win !== 32 || n_valid !== 32) begin
            n_errors++; $display("FAIL vs_recover got fs %0d shifts %0d valid %0d want 1 32 32", n_fs, n_frame_win, n_valid); end
    endtask

    task automatic test_reset_in_flush();
        clear_mon();
        send_frame(4, -1, 4, cfg_ksel_i, cfg_bypass_i);
        n_checks++; if (flush_o !== 1'b1) begin n_errors++; $display("FAIL pre_reset_flush got %b want 1", flush_o); end
        rst_ni = 1'b0;
        drive(1'b0, 1'b0);
        n_checks++; if (all_outs !== '0) begin n_errors++; $display("FAIL flush_reset_outs got %h want 0", all_outs); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_errors++; $display("FAIL flush_reset_state got %0d want %0d", dut.state_q, S_IDLE); end
        rst_ni = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        clear_mon();
        send_frame(4, -1, 12, cfg_ksel_i, cfg_bypass_i);
        check_clean("after_reset");
    endtask

    initial begin
        rst_ni = 1'b0; vs_ni = 1'b1; hs_ni = 1'b1; blank_ni = 1'b0;
        cfg_ksel_i = 2'd0; cfg_bypass_i = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        test_reset();
        test_clean_frame();
        test_cfg_latch();
        test_short_line();
        test_short_vsync();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Sequencer for the 3x3 convolution datapath.
- Decodes the incoming active-low vs/hs/blank stream and gates the sliding-window shift enable to active pixels only.
- Tracks coordinates of the pixel at the window centre and emits border flags so downstream logic can mask edge taps.
- Latches per-frame kernel configuration, and flushes the window after the last pixel so the final line is emitted.

Parameters:
LINE_WIDTH, 640, active pixels per line (W)
FRAME_HEIGHT, 480, active lines per frame (H)
KSEL_W, 2, width of kernel-select config field

Ports:
clk  in  1  pixel clock
rst_ni  in  1  synchronous active-low reset
vs_ni  in  1  vertical sync, active-low
hs_ni  in  1  horizontal sync, active-low
blank_ni  in  1  1 = active pixel
cfg_ksel_i  in  KSEL_W  requested kernel select
cfg_bypass_i  in  1  requested bypass
win_en_o  out  1  sliding-window shift enable
flush_o  out  1  1 = window input mux must feed zero pixel
ctr_valid_o  out  1  window centre holds a real frame pixel
ctr_col_o  out  clog2(W)  centre column
ctr_row_o  out  clog2(H)  centre row
border_o  out  4  {left,right,top,bottom} of centre pixel
ksel_o  out  KSEL_W  frame-latched kernel select
bypass_o  out  1  frame-latched bypass
frame_start_o  out  1  one-cycle pulse at first active pixel of frame
line_err_o  out  1  sticky geometry error

Behaviour:
- All outputs registered; synchronous active-low reset on clk.
- Reset values: all outputs 0, state S_IDLE, all counters 0.
- Latency: outputs describe the input sample presented one cycle earlier. The top level inserts one pixel register ahead of the window.
- Active pixel: blank_ni=1 and vs_ni=1.
- FSM states:
  - S_IDLE: wait for vs_ni=0, then go to S_VSYNC. Outputs idle. A stream joined mid-frame is ignored until the next vsync.
  - S_VSYNC: on vs_ni rising, latch cfg_ksel_i→ksel_o and cfg_bypass_i→bypass_o, clear input counters, go to S_FRAME. Config changes at any other time have no effect.
  - S_FRAME:
    - Each active pixel: win_en_o=1, col_in++.
    - At col_in==W-1: wrap to 0, row_in++.
    - frame_start_o pulses on the first active pixel after S_VSYNC.
    - When vs_ni=0 arrives: if the frame-linear input count p_in ≥ W+1, go to S_FLUSH; otherwise go to S_VSYNC.
  - S_FLUSH: assert win_en_o=1 and flush_o=1 every cycle for exactly W+1 cycles, regardless of sync inputs, then go to S_VSYNC.
    - vs_ni must remain low for at least W+1 cycles. If vs_ni rises during the flush, set line_err_o, finish the flush, and then treat the next vs_ni rising edge normally.
- Centre tracking: the centre lags the input by W+1 shifts.
  - ctr_valid_o=1 on a shift when the total shifts this frame ≥ W+2 (counting flush shifts), else 0.
  - Centre counters start at (0,0) on the first valid shift and advance in raster order, with column wrap at W-1.
  - Centre coverage stops after H·W valid centres; later shifts give ctr_valid_o=0.
  - ctr_valid_o=0 whenever win_en_o=0.
- border_o (meaningful only with ctr_valid_o=1):
  - left = col==0
  - right = col==W-1
  - top = row==0
  - bottom = row==H-1
- Geometry errors set line_err_o sticky until reset:
  - blank_ni falling when col_in≠0 (short or long line). col_in is forced to 0 and row_in++.
  - More than H rows in a frame. row_in saturates at H-1.
- Simultaneous vs_ni fall with an active pixel: the pixel is ignored; vsync wins.
- Reset mid-frame: return to S_IDLE; the window contents are don't-care because ctr_valid_o=0 until a new frame is qualified.

Decomposition:
- Package conv_pkg holds:
  - state enum ctrl_state_t {S_IDLE, S_VSYNC, S_FRAME, S_FLUSH}
  - border bit index constants BRD_LEFT=3, BRD_RIGHT=2, BRD_TOP=1, BRD_BOTTOM=0
- One sub-module, raster_counter, a col/row counter with enable, clear, and wrap-at-W/H outputs. It is instantiated twice: input position and centre position.

Test Plan (W=8, H=4 unless noted):
1. Reset held low 3 cycles with active stream → all outputs 0, no win_en_o until after the first vsync.
2. Clean frame, 4 lines of 8 active pixels:
   - win_en_o pulses 32 times during S_FRAME.
   - First ctr_valid_o occurs on the 10th shift with (col,row)=(0,0) and border_o=4'b1010.
   - Then vsync triggers exactly 9 flush cycles with flush_o=1.
   - Total ctr_valid_o count is 32; the last centre is (7,3) with border_o=4'b0101.
3. cfg_ksel_i=2 during the frame, changed to 1 mid-frame → ksel_o becomes 2 only at the next vs_ni rise and stays 2 for that whole frame.
4. Line of 7 pixels then blank → line_err_o=1 and stays set. The next line counts from col 0.
5. vs_ni high only 4 cycles after the frame → flush completes all 9 cycles and line_err_o=1.
6. rst_ni asserted during S_FLUSH → next cycle all outputs 0 and state S_IDLE; a following clean frame behaves as in test 2.
